// File: rtl/can_register_pkg.sv
// ---------------------------------------------------------------------------
// can_register_pkg
// Shared definitions for the CAN register bank.
//   regMode_t : per-register access mode
//     RW   - plain read/write register
//     CMD  - self-clearing command register (one-cycle pulse per write)
//     RC   - hardware-set, clear-on-read status register
//     LOCK - read/write only while the core is in reset mode
// ---------------------------------------------------------------------------
package can_register_pkg;

  typedef enum logic [1:0] {
    RW   = 2'd0,
    CMD  = 2'd1,
    RC   = 2'd2,
    LOCK = 2'd3
  } regMode_t;

endpackage

// File: rtl/can_register_cell.sv
// ---------------------------------------------------------------------------
// can_register_cell
// One WIDTH-bit register whose next-state behaviour is chosen by CELL_MODE.
// Ports:
//   clk_i, rst_i   - clock, asynchronous active-high reset
//   wrEn_i         - write strobe already decoded for this register
//   rdEn_i         - read strobe already decoded for this register
//   resetMode_i    - core is in reset mode (unlocks LOCK registers)
//   data_in_i      - write data
//   hw_set_i       - per-bit set requests (RC registers only)
//   value_o        - live register contents
// ---------------------------------------------------------------------------
module can_register_cell
  import can_register_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter regMode_t         CELL_MODE = RW,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wrEn_i,
  input  logic             rdEn_i,
  input  logic             resetMode_i,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic [WIDTH-1:0] hw_set_i,
  output logic [WIDTH-1:0] value_o
);

  // Command registers always come out of reset idle, whatever value the
  // bank asked for, so no spurious command fires after reset.
  localparam logic [WIDTH-1:0] RESET_EFF = (CELL_MODE == CMD) ? '0 : RESET_VAL;

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // Next-state selection per mode. CMD falls back to zero whenever no write
  // is present, which gives back-to-back pulses for back-to-back writes.
  // RC lets hw_set win over the read clear so an event arriving on the
  // read cycle is kept for the next read.
  always_comb begin
    value_d = value_q;
    case (CELL_MODE)
      RW: begin
        if (wrEn_i) value_d = data_in_i;
      end
      CMD: begin
        value_d = wrEn_i ? data_in_i : '0;
      end
      RC: begin
        value_d = (value_q & ~{WIDTH{rdEn_i}}) | hw_set_i;
      end
      LOCK: begin
        if (wrEn_i && resetMode_i) value_d = data_in_i;
      end
      default: value_d = value_q;
    endcase
  end

  // State register with asynchronous reset to the mode-adjusted reset value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) value_q <= RESET_EFF;
    else       value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/can_register_bank.sv
// ---------------------------------------------------------------------------
// can_register_bank
// Bank of NUM_REGS control/status registers between the host register
// interface and the CAN core, each with its own access mode.
// Ports:
//   clk_i, rst_i     - clock, asynchronous active-high reset
//   addr_i           - register address for reads and writes
//   data_in_i        - write data
//   we_i / re_i      - one-cycle write / read strobes
//   reset_mode_i     - core in reset mode, unlocks LOCK registers
//   hw_set_i         - per-bit set requests, honoured only by RC registers
//   data_out_o       - registered read data, held until the next read
//   rd_valid_o       - one-cycle pulse, data_out_o valid
//   write_err_o      - one-cycle pulse, previous write was rejected
//   regs_out_o       - live contents of every register
// ---------------------------------------------------------------------------
module can_register_bank
  import can_register_pkg::*;
#(
  parameter int                          WIDTH       = 8,
  parameter int                          NUM_REGS    = 4,
  parameter int                          ADDR_W      = $clog2(NUM_REGS),
  parameter logic [NUM_REGS*WIDTH-1:0]   RESET_VALUE = '0,
  parameter logic [2*NUM_REGS-1:0]       MODE        = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [ADDR_W-1:0]         addr_i,
  input  logic [WIDTH-1:0]          data_in_i,
  input  logic                      we_i,
  input  logic                      re_i,
  input  logic                      reset_mode_i,
  input  logic [NUM_REGS*WIDTH-1:0] hw_set_i,
  output logic [WIDTH-1:0]          data_out_o,
  output logic                      rd_valid_o,
  output logic                      write_err_o,
  output logic [NUM_REGS*WIDTH-1:0] regs_out_o
);

  logic [NUM_REGS-1:0]       wrHit;
  logic [NUM_REGS-1:0]       rdHit;
  logic [NUM_REGS*WIDTH-1:0] regsAll;
  logic [WIDTH-1:0]          readMux;
  logic [1:0]                modeSel;
  logic                      inRange;
  logic                      wrErr;

  logic [WIDTH-1:0] dataOut_q;
  logic             rdValid_q;
  logic             writeErr_q;

  // Address decode, read mux and write-rejection check. The address is
  // compared against every index rather than used as an array index, so a
  // non-power-of-two bank simply matches nothing for unused addresses and
  // the read mux falls back to zero. CMD registers always read as zero.
  always_comb begin
    wrHit   = '0;
    rdHit   = '0;
    readMux = '0;
    modeSel = RW;
    inRange = ({1'b0, addr_i} < (ADDR_W + 1)'(NUM_REGS));
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_i == ADDR_W'(i)) begin
        wrHit[i] = we_i;
        rdHit[i] = re_i;
        modeSel  = MODE[2*i +: 2];
        if (MODE[2*i +: 2] != CMD) readMux = regsAll[i*WIDTH +: WIDTH];
      end
    end
    wrErr = we_i && (!inRange || (modeSel == RC) ||
                     ((modeSel == LOCK) && !reset_mode_i));
  end

  // One cell per register; each cell owns its mode-specific next state.
  for (genvar g = 0; g < NUM_REGS; g++) begin : gen_cell
    can_register_cell #(
      .WIDTH     (WIDTH),
      .CELL_MODE (regMode_t'(MODE[2*g +: 2])),
      .RESET_VAL (RESET_VALUE[g*WIDTH +: WIDTH])
    ) u_cell (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .wrEn_i      (wrHit[g]),
      .rdEn_i      (rdHit[g]),
      .resetMode_i (reset_mode_i),
      .data_in_i   (data_in_i),
      .hw_set_i    (hw_set_i[g*WIDTH +: WIDTH]),
      .value_o     (regsAll[g*WIDTH +: WIDTH])
    );
  end

  // Read data and status pulses. data_out only moves on a read so the host
  // can sample it at leisure; the RC clear lands on this same edge, which is
  // why the captured value is the pre-clear one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dataOut_q  <= '0;
      rdValid_q  <= 1'b0;
      writeErr_q <= 1'b0;
    end else begin
      if (re_i) dataOut_q <= readMux;
      rdValid_q  <= re_i;
      writeErr_q <= wrErr;
    end
  end

  assign data_out_o  = dataOut_q;
  assign rd_valid_o  = rdValid_q;
  assign write_err_o = writeErr_q;
  assign regs_out_o  = regsAll;

endmodule

// File: tb/tb_can_register_bank.sv
// ---------------------------------------------------------------------------
// tb_can_register_bank
// Directed bench for can_register_bank. Main instance: 4 registers with
// modes {LOCK, RC, CMD, RW} for regs 3..0. A second 3-register instance
// exercises the out-of-range address behaviour.
// ---------------------------------------------------------------------------
module tb_can_register_bank;
  import can_register_pkg::*;

  localparam logic [31:0] RESET_VAL4 = 32'h5A_00_77_A5;
  localparam logic [7:0]  MODE4      = {LOCK, RC, CMD, RW};
  localparam logic [23:0] RESET_VAL3 = 24'h00_00_11;
  localparam logic [5:0]  MODE3      = {RC, CMD, RW};

  logic        clk;
  logic        rst;

  logic [1:0]  addr;
  logic [7:0]  dataIn;
  logic        we;
  logic        re;
  logic        resetMode;
  logic [31:0] hwSet;
  logic [7:0]  dataOut;
  logic        rdValid;
  logic        writeErr;
  logic [31:0] regsOut;

  logic [1:0]  addr3;
  logic [7:0]  dataIn3;
  logic        we3;
  logic        re3;
  logic [7:0]  dataOut3;
  logic        rdValid3;
  logic        writeErr3;
  logic [23:0] regsOut3;

  logic [7:0]  expQ[$];
  int          checks = 0;
  int          errors = 0;

  can_register_bank #(
    .WIDTH       (8),
    .NUM_REGS    (4),
    .RESET_VALUE (RESET_VAL4),
    .MODE        (MODE4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .addr_i       (addr),
    .data_in_i    (dataIn),
    .we_i         (we),
    .re_i         (re),
    .reset_mode_i (resetMode),
    .hw_set_i     (hwSet),
    .data_out_o   (dataOut),
    .rd_valid_o   (rdValid),
    .write_err_o  (writeErr),
    .regs_out_o   (regsOut)
  );

  can_register_bank #(
    .WIDTH       (8),
    .NUM_REGS    (3),
    .RESET_VALUE (RESET_VAL3),
    .MODE        (MODE3)
  ) dut3 (
    .clk_i        (clk),
    .rst_i        (rst),
    .addr_i       (addr3),
    .data_in_i    (dataIn3),
    .we_i         (we3),
    .re_i         (re3),
    .reset_mode_i (1'b0),
    .hw_set_i     (24'h0),
    .data_out_o   (dataOut3),
    .rd_valid_o   (rdValid3),
    .write_err_o  (writeErr3),
    .regs_out_o   (regsOut3)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where outputs are settled
  // and new inputs can be driven for the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive all inputs of the main instance in one go.
  task automatic applyStimulus(input logic w, input logic r, input logic [1:0] a,
                               input logic [7:0] d, input logic [31:0] hs);
    we     = w;
    re     = r;
    addr   = a;
    dataIn = d;
    hwSet  = hs;
  endtask

  // Single comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Pops the oldest expected read result and compares it with the returned
  // data; also requires the valid pulse.
  task automatic checkRead(input string tag, input logic [7:0] obsData,
                           input logic obsValid);
    logic [7:0] expData;
    checkOutput({tag, "_valid"}, {31'd0, obsValid}, 32'd1);
    if (expQ.size() == 0) begin
      checkOutput({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      expData = expQ.pop_front();
      checkOutput(tag, {24'd0, obsData}, {24'd0, expData});
    end
  endtask

  initial begin
    rst       = 1'b1;
    resetMode = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 32'h0);
    addr3 = 2'd0; dataIn3 = 8'h00; we3 = 1'b0; re3 = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_regs", regsOut, 32'h5A_00_00_A5);
    checkOutput("reset_data_out", {24'd0, dataOut}, 32'h0);
    checkOutput("reset_rd_valid", {31'd0, rdValid}, 32'h0);
    checkOutput("reset_write_err", {31'd0, writeErr}, 32'h0);
    checkOutput("reset_regs3", {8'd0, regsOut3}, 32'h00_00_00_11);
    rst = 1'b0;
    tick();

    // RW: read reset value, write, read back
    applyStimulus(1'b0, 1'b1, 2'd0, 8'h00, 32'h0); expQ.push_back(8'hA5);
    tick(); checkRead("rw_read_reset", dataOut, rdValid);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 32'h0);
    tick();
    checkOutput("rd_valid_one_cycle", {31'd0, rdValid}, 32'h0);
    checkOutput("data_out_hold", {24'd0, dataOut}, 32'hA5);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h3C, 32'h0);
    tick();
    checkOutput("rw_write", {24'd0, regsOut[7:0]}, 32'h3C);
    checkOutput("rw_write_no_err", {31'd0, writeErr}, 32'h0);
    applyStimulus(1'b0, 1'b1, 2'd0, 8'h00, 32'h0); expQ.push_back(8'h3C);
    tick(); checkRead("rw_read_back", dataOut, rdValid);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 32'h0);
    tick(); checkOutput("rw_rd_valid_drop", {31'd0, rdValid}, 32'h0);

    // CMD: single pulse, back-to-back pulses, read returns zero
    applyStimulus(1'b1, 1'b0, 2'd1, 8'h01, 32'h0);
    tick(); checkOutput("cmd_pulse", {24'd0, regsOut[15:8]}, 32'h01);
    applyStimulus(1'b0, 1'b0, 2'd1, 8'h00, 32'h0);
    tick(); checkOutput("cmd_self_clear", {24'd0, regsOut[15:8]}, 32'h00);
    applyStimulus(1'b1, 1'b0, 2'd1, 8'h01, 32'h0);
    tick(); checkOutput("cmd_b2b_first", {24'd0, regsOut[15:8]}, 32'h01);
    tick(); checkOutput("cmd_b2b_second", {24'd0, regsOut[15:8]}, 32'h01);
    applyStimulus(1'b0, 1'b0, 2'd1, 8'h00, 32'h0);
    tick(); checkOutput("cmd_b2b_clear", {24'd0, regsOut[15:8]}, 32'h00);
    applyStimulus(1'b1, 1'b0, 2'd1, 8'h55, 32'h0);
    tick(); checkOutput("cmd_pulse_55", {24'd0, regsOut[15:8]}, 32'h55);
    applyStimulus(1'b0, 1'b1, 2'd1, 8'h00, 32'h0); expQ.push_back(8'h00);
    tick(); checkRead("cmd_read_zero", dataOut, rdValid);
    checkOutput("cmd_after_read", {24'd0, regsOut[15:8]}, 32'h00);

    // RC: hw_set, clear-on-read, set/clear race; hw_set ignored elsewhere
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 32'h01_08_00_00);
    tick(); checkOutput("rc_hw_set", regsOut, 32'h5A_08_00_3C);
    applyStimulus(1'b0, 1'b1, 2'd2, 8'h00, 32'h0); expQ.push_back(8'h08);
    tick(); checkRead("rc_read", dataOut, rdValid);
    checkOutput("rc_cleared", {24'd0, regsOut[23:16]}, 32'h00);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 32'h00_08_00_00);
    tick(); checkOutput("rc_hw_set_again", {24'd0, regsOut[23:16]}, 32'h08);
    applyStimulus(1'b0, 1'b1, 2'd2, 8'h00, 32'h00_01_00_00); expQ.push_back(8'h08);
    tick(); checkRead("rc_race_read", dataOut, rdValid);
    checkOutput("rc_race_set_wins", {24'd0, regsOut[23:16]}, 32'h01);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 32'h0);
    tick(); checkOutput("rc_sticky", {24'd0, regsOut[23:16]}, 32'h01);
    applyStimulus(1'b1, 1'b0, 2'd2, 8'hFF, 32'h0);
    tick();
    checkOutput("rc_write_err", {31'd0, writeErr}, 32'h1);
    checkOutput("rc_write_ignored", {24'd0, regsOut[23:16]}, 32'h01);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 32'h0);
    tick(); checkOutput("write_err_pulse", {31'd0, writeErr}, 32'h0);

    // LOCK: locked outside reset mode, writable inside
    resetMode = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'd3, 8'hFF, 32'h0);
    tick();
    checkOutput("lock_write_err", {31'd0, writeErr}, 32'h1);
    checkOutput("lock_unchanged", {24'd0, regsOut[31:24]}, 32'h5A);
    resetMode = 1'b1;
    tick();
    checkOutput("lock_unlocked_no_err", {31'd0, writeErr}, 32'h0);
    checkOutput("lock_written", {24'd0, regsOut[31:24]}, 32'hFF);
    resetMode = 1'b0;

    // we and re together at the same address
    applyStimulus(1'b1, 1'b1, 2'd2, 8'hFF, 32'h0); expQ.push_back(8'h01);
    tick(); checkRead("rc_we_re_read", dataOut, rdValid);
    checkOutput("rc_we_re_cleared", {24'd0, regsOut[23:16]}, 32'h00);
    checkOutput("rc_we_re_err", {31'd0, writeErr}, 32'h1);
    applyStimulus(1'b1, 1'b1, 2'd0, 8'h77, 32'h0); expQ.push_back(8'h3C);
    tick(); checkRead("rw_we_re_read", dataOut, rdValid);
    checkOutput("rw_we_re_written", {24'd0, regsOut[7:0]}, 32'h77);
    checkOutput("rw_we_re_no_err", {31'd0, writeErr}, 32'h0);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 32'h0);

    // Out-of-range address on the 3-register bank
    re3 = 1'b1; addr3 = 2'd0; expQ.push_back(8'h11);
    tick(); checkRead("bank3_read0", dataOut3, rdValid3);
    addr3 = 2'd3; expQ.push_back(8'h00);
    tick(); checkRead("oor_read", dataOut3, rdValid3);
    re3 = 1'b0; we3 = 1'b1; dataIn3 = 8'hFF;
    tick();
    checkOutput("oor_write_err", {31'd0, writeErr3}, 32'h1);
    checkOutput("oor_write_ignored", {8'd0, regsOut3}, 32'h00_00_00_11);
    we3 = 1'b0;

    // Asynchronous reset in the middle of a pending read and write
    applyStimulus(1'b1, 1'b1, 2'd0, 8'h99, 32'h0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_regs", regsOut, 32'h5A_00_00_A5);
    checkOutput("async_data_out", {24'd0, dataOut}, 32'h0);
    checkOutput("async_write_err3", {31'd0, writeErr3}, 32'h0);
    checkOutput("async_regs3", {8'd0, regsOut3}, 32'h00_00_00_11);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 32'h0);
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    checkOutput("post_reset_rd_valid", {31'd0, rdValid}, 32'h0);
    checkOutput("post_reset_write_err", {31'd0, writeErr}, 32'h0);
    checkOutput("post_reset_regs", regsOut, 32'h5A_00_00_A5);
    checkOutput("post_reset_data_out", {24'd0, dataOut}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/can_register_bank.md
# can_register_bank

Parametrised bank of `NUM_REGS` control/status registers, each `WIDTH` bits, with per-register access mode. It sits between the host register interface and the CAN core. It replaces individually instantiated single registers and adds:
- self-clearing command registers
- hardware-set, clear-on-read status registers
- registers lockable outside reset mode, e.g. acceptance code/mask

## Interface
Parameters:
- `WIDTH`, 8, bits per register
- `NUM_REGS`, 4, number of registers; must be ≥ 2
- `ADDR_W`, `$clog2(NUM_REGS)`, address width
- `RESET_VALUE`, 0, packed `NUM_REGS*WIDTH`; register i reset value at `[i*WIDTH +: WIDTH]`
- `MODE`, 0, packed `2*NUM_REGS`; register i mode at `[2*i +: 2]` (`RW`=0, `CMD`=1, `RC`=2, `LOCK`=3)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `addr`  in  `ADDR_W`  register address for read and write
- `data_in`  in  `WIDTH`  write data
- `we`  in  1  write strobe, one cycle per write
- `re`  in  1  read strobe, one cycle per read
- `reset_mode`  in  1  core is in reset mode; enables writes to `LOCK` registers
- `hw_set`  in  `NUM_REGS*WIDTH`  per-bit set requests; used only by `RC` registers
- `data_out`  out  `WIDTH`  registered read data
- `rd_valid`  out  1  `data_out` valid, one-cycle pulse
- `write_err`  out  1  rejected write, one-cycle pulse
- `regs_out`  out  `NUM_REGS*WIDTH`  live contents of all registers

## Operation
- **Reset:** `rst` high immediately sets every register i to `RESET_VALUE[i]`, except `CMD` registers, which reset to 0. `data_out`, `rd_valid` and `write_err` reset to 0. Reset mid-operation aborts any pending read, write or clear; no pulse is emitted afterwards.
- **RW:** on `we`, the register takes `data_in` at the next edge and holds it.
- **CMD:** on `we`, the register takes `data_in` for exactly one cycle, then returns to 0.
  - Writes on consecutive cycles give consecutive pulses, with no zero cycle between them.
  - Reads of a `CMD` register return 0.
- **RC:** next value is `(reg & ~clr) | hw_set_i`. `clr` is all-ones when `re` addresses this register, otherwise 0.
  - On a simultaneous clear and `hw_set`, set wins, so no event is lost.
  - `data_out` returns the pre-clear value.
  - `we` to an `RC` register is ignored and raises `write_err`.
  - `hw_set` is ignored for all other modes.
- **LOCK:** behaves as `RW` when `reset_mode`=1. When `reset_mode`=0, `we` is ignored and raises `write_err`.
- **Out-of-range address** (`addr` ≥ `NUM_REGS`):
  - a write is ignored and raises `write_err`;
  - a read returns 0 with `rd_valid`=1.
- **`we` and `re` together at the same address:** the read returns the old value and the write applies. For `RC`, the clear applies and the write is rejected.

## Timing
- Writes take effect at the first edge after `we`, so `regs_out` updates 1 cycle after the strobe.
- Read latency is 1 cycle: `data_out` and `rd_valid` assert on the cycle after `re`. `data_out` holds its value until the next read.
- The `RC` clear lands on the same edge that captures `data_out`.
- `write_err` asserts 1 cycle after the offending `we`.
- `CMD` output is high for exactly the one cycle following `we`.
- `hw_set` is sampled every edge and is reflected in `regs_out` 1 cycle later.
- No backpressure: a strobe may be issued every cycle.

## Structure
- Package `can_register_pkg` holds the mode constants `RW`, `CMD`, `RC` and `LOCK` as a 2-bit typedef.
- Sub-module `can_register_cell` implements one register of `WIDTH` bits with its mode logic. It takes mode and reset value as parameters and is instantiated `NUM_REGS` times by a generate loop.
- The bank contains address decode, read mux, `data_out`/`rd_valid`/`write_err` flops and error detection.

## Test plan
Bench configuration: `WIDTH`=8, `NUM_REGS`=4, `MODE`={`LOCK`,`RC`,`CMD`,`RW`} for registers 3..0.
- **RW write/read:** `RESET_VALUE` reg0=0xA5; after reset, `re` addr0 gives `data_out`=0xA5. Write 0x3C to addr0, then read it: `data_out`=0x3C, `rd_valid` high for 1 cycle.
- **CMD pulse:** write 0x01 to addr1 → `regs_out[15:8]`=0x01 for exactly 1 cycle, then 0x00. Write on two consecutive cycles → high for 2 cycles. A read returns 0x00.
- **RC clear and race:**
  - Pulse `hw_set` bit 3 of reg2 → reg2=0x08. Read → `data_out`=0x08, reg2=0x00 next cycle.
  - `hw_set` bit 0 in the same cycle as `re` → `data_out`=0x08, reg2=0x01.
- **LOCK:**
  - `reset_mode`=0, write 0xFF to addr3 → `write_err` pulse, reg3 unchanged.
  - `reset_mode`=1, write 0xFF → reg3=0xFF, no error.
- **Errors:** write to addr2 (`RC`) → `write_err`, no change. With `NUM_REGS`=3, read addr3 → `data_out`=0x00, `rd_valid`=1.
- **Async reset mid-operation:** assert `rst` between edges during a write to addr0 → all outputs and registers reset immediately. No `rd_valid` or `write_err` pulse appears after release.
